// File: rtl/pc_sequencer.sv
// Registered program counter for the fetch stage: condition evaluation, jumps,
// signed PC-relative branches, jump-and-link and a circular return-address stack.
module pc_sequencer #(
  parameter int                ADDR_W    = 16,
  parameter int                DISP_W    = 8,
  parameter int                RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [7:0]        op,
  input  logic [3:0]        cond,
  input  logic [DISP_W-1:0] disp,
  input  logic [ADDR_W-1:0] target,
  input  logic [4:0]        flags,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link,
  output logic              taken,
  output logic              ras_empty,
  output logic              ras_ovf
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] link_q, link_d;
  logic              taken_q, taken_d;
  logic              ras_ovf_q, ras_ovf_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_tgt;
  logic [ADDR_W-1:0] disp_ext;
  logic [PTR_W-1:0]  ptr_dec;
  logic              ras_full;
  logic              cond_true;

  // flags layout: [0]=C [1]=L [2]=F [3]=Z [4]=N
  function automatic logic cond_eval(input logic [3:0] c, input logic [4:0] f);
    logic res;
    case (c)
      4'h0:    res = f[3];
      4'h1:    res = !f[3];
      4'h2:    res = f[0];
      4'h3:    res = !f[0];
      4'h4:    res = f[1];
      4'h5:    res = !f[1];
      4'h6:    res = f[4];
      4'h7:    res = !f[4];
      4'h8:    res = f[2];
      4'h9:    res = !f[2];
      4'hA:    res = !f[1] && !f[3];
      4'hB:    res = f[1] || f[3];
      4'hC:    res = !f[4] && !f[3];
      4'hD:    res = f[4] || f[3];
      4'hE:    res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  assign disp_ext  = ADDR_W'($signed(disp));
  assign pc_inc    = pc_q + ADDR_W'(1);
  assign br_tgt    = pc_q + disp_ext;
  assign ptr_dec   = ptr_q - PTR_W'(1);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign cond_true = cond_eval(cond, flags);

  always_comb begin
    pc_d      = pc_q;
    link_d    = link_q;
    taken_d   = 1'b0;
    ras_ovf_d = 1'b0;
    ras_d     = ras_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    if (en) begin
      pc_d = pc_inc;
      case (op[7:4])
        4'b0100: begin
          if (op[3:0] == 4'b1000) begin
            pc_d          = target;
            link_d        = pc_inc;
            taken_d       = 1'b1;
            ras_d[ptr_q]  = pc_inc;
            ptr_d         = ptr_q + PTR_W'(1);
            // A full stack overwrites the oldest slot, which is where ptr already points
            if (ras_full) ras_ovf_d = 1'b1;
            else          cnt_d     = cnt_q + CNT_W'(1);
          end else if (op[3:0] == 4'b0100) begin
            taken_d = 1'b1;
            if (cnt_q != '0) begin
              pc_d  = ras_q[ptr_dec];
              ptr_d = ptr_dec;
              cnt_d = cnt_q - CNT_W'(1);
            end else begin
              pc_d = target;
            end
          end else if (cond_true) begin
            pc_d    = target;
            taken_d = 1'b1;
          end
        end
        4'b1100: begin
          if (cond_true) begin
            pc_d    = br_tgt;
            taken_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      link_q    <= '0;
      taken_q   <= 1'b0;
      ras_ovf_q <= 1'b0;
      ras_q     <= '{default: '0};
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      link_q    <= link_d;
      taken_q   <= taken_d;
      ras_ovf_q <= ras_ovf_d;
      ras_q     <= ras_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc        = pc_q;
  assign link      = link_q;
  assign taken     = taken_q;
  assign ras_ovf   = ras_ovf_q;
  assign ras_empty = (cnt_q == '0);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, branches, condition sweep, JAL/RET,
// RAS overflow, address wrap, stalls and asynchronous reset.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  op;
  logic [3:0]  cond;
  logic [7:0]  disp;
  logic [15:0] target;
  logic [4:0]  flags;
  logic [15:0] pc;
  logic [15:0] link;
  logic        taken;
  logic        ras_empty;
  logic        ras_ovf;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(
    .ADDR_W(16), .DISP_W(8), .RAS_DEPTH(4), .RESET_PC(16'h0100)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .cond(cond), .disp(disp),
    .target(target), .flags(flags), .pc(pc), .link(link), .taken(taken),
    .ras_empty(ras_empty), .ras_ovf(ras_ovf)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic e, input logic [7:0] o, input logic [3:0] c,
                      input logic [7:0] d, input logic [15:0] t, input logic [4:0] f);
    en = e; op = o; cond = c; disp = d; target = t; flags = f;
    @(posedge clk);
    #1;
  endtask

  // Unconditional Jcond used to place the PC; does not touch the RAS.
  task automatic set_pc(input logic [15:0] a);
    step(1'b1, 8'h40, 4'hE, 8'h00, a, 5'd0);
  endtask

  function automatic logic model_cond(input logic [3:0] c, input logic [4:0] f);
    logic cf, lf, ff, zf, nf;
    cf = f[0]; lf = f[1]; ff = f[2]; zf = f[3]; nf = f[4];
    case (c)
      4'd0:  return zf;
      4'd1:  return ~zf;
      4'd2:  return cf;
      4'd3:  return ~cf;
      4'd4:  return lf;
      4'd5:  return ~lf;
      4'd6:  return nf;
      4'd7:  return ~nf;
      4'd8:  return ff;
      4'd9:  return ~ff;
      4'd10: return ~(lf | zf);
      4'd11: return lf | zf;
      4'd12: return ~(nf | zf);
      4'd13: return nf | zf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; op = 8'h00; cond = 4'h0; disp = 8'h00; target = 16'h0; flags = 5'd0;
    #2;
    total++; if (pc !== 16'h0100) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=0100", pc); end
    total++; if (link !== 16'h0000) begin bad++; $display("[TB] FAIL reset_link got=%h exp=0000", link); end
    total++; if (taken !== 1'b0) begin bad++; $display("[TB] FAIL reset_taken got=%b exp=0", taken); end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("[TB] FAIL reset_ras_empty got=%b exp=1", ras_empty); end
    total++; if (ras_ovf !== 1'b0) begin bad++; $display("[TB] FAIL reset_ras_ovf got=%b exp=0", ras_ovf); end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 8'h00, 4'h0, 8'h00, 16'h0, 5'd0);
      total++; if (pc !== 16'h0100 + 16'(i)) begin bad++; $display("[TB] FAIL seq_pc%0d got=%h exp=%h", i, pc, 16'h0100 + 16'(i)); end
      total++; if (taken !== 1'b0) begin bad++; $display("[TB] FAIL seq_taken%0d got=%b exp=0", i, taken); end
    end
  endtask

  task automatic test_branch;
    set_pc(16'h0020);
    step(1'b1, 8'hC0, 4'h0, 8'hFC, 16'h0, 5'b01000);
    total++; if (pc !== 16'h001C) begin bad++; $display("[TB] FAIL beq_taken_pc got=%h exp=001c", pc); end
    total++; if (taken !== 1'b1) begin bad++; $display("[TB] FAIL beq_taken got=%b exp=1", taken); end
    set_pc(16'h0020);
    step(1'b1, 8'hC0, 4'h0, 8'hFC, 16'h0, 5'b00000);
    total++; if (pc !== 16'h0021) begin bad++; $display("[TB] FAIL beq_nt_pc got=%h exp=0021", pc); end
    total++; if (taken !== 1'b0) begin bad++; $display("[TB] FAIL beq_nt_taken got=%b exp=0", taken); end
    set_pc(16'h0030);
    step(1'b1, 8'hC0, 4'hC, 8'h05, 16'h0, 5'b00100);
    total++; if (pc !== 16'h0035) begin bad++; $display("[TB] FAIL lt_fset_pc got=%h exp=0035", pc); end
    step(1'b1, 8'hC0, 4'hF, 8'h05, 16'h0, 5'b11111);
    total++; if (pc !== 16'h0036) begin bad++; $display("[TB] FAIL nv_pc got=%h exp=0036", pc); end
  endtask

  task automatic test_cond_sweep;
    logic [15:0] exp_pc;
    logic        exp_tk;
    set_pc(16'h0800);
    exp_pc = 16'h0800;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 32; f++) begin
        step(1'b1, 8'hC3, 4'(c), 8'h04, 16'hDEAD, 5'(f));
        exp_tk = model_cond(4'(c), 5'(f));
        exp_pc = exp_tk ? exp_pc + 16'd4 : exp_pc + 16'd1;
        total++;
        if (pc !== exp_pc || taken !== exp_tk) begin
          bad++;
          $display("[TB] FAIL sweep c=%0d f=%0d got pc=%h tk=%b exp pc=%h tk=%b", c, f, pc, taken, exp_pc, exp_tk);
        end
      end
    end
  endtask

  task automatic test_jal_ret;
    set_pc(16'h0040);
    step(1'b1, 8'h48, 4'hF, 8'h00, 16'h0200, 5'd0);
    total++; if (pc !== 16'h0200) begin bad++; $display("[TB] FAIL jal_pc got=%h exp=0200", pc); end
    total++; if (link !== 16'h0041) begin bad++; $display("[TB] FAIL jal_link got=%h exp=0041", link); end
    total++; if (ras_empty !== 1'b0) begin bad++; $display("[TB] FAIL jal_ras_empty got=%b exp=0", ras_empty); end
    total++; if (taken !== 1'b1) begin bad++; $display("[TB] FAIL jal_taken got=%b exp=1", taken); end
    step(1'b1, 8'h44, 4'hF, 8'h00, 16'h0777, 5'd0);
    total++; if (pc !== 16'h0041) begin bad++; $display("[TB] FAIL ret_pc got=%h exp=0041", pc); end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("[TB] FAIL ret_ras_empty got=%b exp=1", ras_empty); end
    step(1'b1, 8'h44, 4'h0, 8'h00, 16'h0300, 5'd0);
    total++; if (pc !== 16'h0300) begin bad++; $display("[TB] FAIL ret_empty_pc got=%h exp=0300", pc); end
    total++; if (taken !== 1'b1) begin bad++; $display("[TB] FAIL ret_empty_taken got=%b exp=1", taken); end
  endtask

  task automatic test_ras_overflow;
    logic [15:0] exp_ret [4] = '{16'h0051, 16'h0041, 16'h0031, 16'h0021};
    for (int i = 1; i <= 5; i++) begin
      set_pc(16'(i * 16));
      step(1'b1, 8'h48, 4'h0, 8'h00, 16'h1000, 5'd0);
      total++; if (ras_ovf !== (i == 5)) begin bad++; $display("[TB] FAIL ovf_jal%0d got=%b exp=%b", i, ras_ovf, (i == 5)); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 8'h44, 4'h0, 8'h00, 16'h0ABC, 5'd0);
      total++; if (pc !== exp_ret[i]) begin bad++; $display("[TB] FAIL ovf_ret%0d got=%h exp=%h", i, pc, exp_ret[i]); end
      if (i == 0) begin
        total++; if (ras_ovf !== 1'b0) begin bad++; $display("[TB] FAIL ovf_pulse_width got=%b exp=0", ras_ovf); end
      end
    end
    total++; if (ras_empty !== 1'b1) begin bad++; $display("[TB] FAIL ovf_ras_empty got=%b exp=1", ras_empty); end
  endtask

  task automatic test_wrap;
    set_pc(16'hFFFF);
    step(1'b1, 8'h00, 4'h0, 8'h00, 16'h0, 5'd0);
    total++; if (pc !== 16'h0000) begin bad++; $display("[TB] FAIL wrap_inc got=%h exp=0000", pc); end
    set_pc(16'hFFFE);
    step(1'b1, 8'hC0, 4'hE, 8'h03, 16'h0, 5'd0);
    total++; if (pc !== 16'h0001) begin bad++; $display("[TB] FAIL wrap_branch got=%h exp=0001", pc); end
    step(1'b1, 8'h41, 4'hF, 8'h00, 16'h0999, 5'd0);
    total++; if (pc !== 16'h0002 || taken !== 1'b0) begin bad++; $display("[TB] FAIL jcond_false got pc=%h tk=%b exp pc=0002 tk=0", pc, taken); end
    step(1'b1, 8'h40, 4'hE, 8'h00, 16'h0003, 5'd0);
    total++; if (pc !== 16'h0003 || taken !== 1'b1) begin bad++; $display("[TB] FAIL jcond_seq_target got pc=%h tk=%b exp pc=0003 tk=1", pc, taken); end
  endtask

  task automatic test_stall_reset;
    set_pc(16'h0060);
    step(1'b1, 8'h48, 4'h0, 8'h00, 16'h0200, 5'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h48, 4'h0, 8'h00, 16'h0400, 5'd0);
      total++;
      if (pc !== 16'h0200 || link !== 16'h0061 || taken !== 1'b0 || ras_empty !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stall%0d got pc=%h link=%h tk=%b re=%b exp pc=0200 link=0061 tk=0 re=0", i, pc, link, taken, ras_empty);
      end
    end
    #2 reset = 1'b1;
    #1;
    total++; if (pc !== 16'h0100) begin bad++; $display("[TB] FAIL async_reset_pc got=%h exp=0100", pc); end
    total++; if (link !== 16'h0000 || ras_empty !== 1'b1) begin bad++; $display("[TB] FAIL async_reset_state got link=%h re=%b exp link=0000 re=1", link, ras_empty); end
    @(posedge clk); #1;
    reset = 1'b0;
    step(1'b1, 8'h44, 4'h0, 8'h00, 16'h0555, 5'd0);
    total++; if (pc !== 16'h0555) begin bad++; $display("[TB] FAIL post_reset_ret got=%h exp=0555", pc); end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_cond_sweep();
    test_jal_ret();
    test_ras_overflow();
    test_wrap();
    test_stall_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
